// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT FFT stage sequencer.
// Holds the controller state encoding, the stage-index width and the NFFT helper.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_FLUSH
    } state_t;

    localparam int unsigned STG_W = 3;

    function automatic int unsigned nfft(input int unsigned size_data_fi);
        return 32'd1 << size_data_fi;
    endfunction

endpackage

// File: rtl/fft_stage_sched_if.sv
// Control/address bundle between the FFT stage sequencer (master) and the
// butterfly datapath plus twiddle ROM (slave).
interface fft_stage_sched_if #(
    parameter int unsigned SIZE_DATA_FI = 3
);
    import fft_pkg::*;

    logic                    start;
    logic                    stall;
    logic [SIZE_DATA_FI-2:0] tw_addr;
    logic                    issue;
    logic                    bfly_valid;
    logic [SIZE_DATA_FI-1:0] addr_a;
    logic [SIZE_DATA_FI-1:0] addr_b;
    logic [STG_W-1:0]        stage;
    logic                    busy;
    logic                    done;

    modport master (
        input  start, stall,
        output tw_addr, issue, bfly_valid, addr_a, addr_b, stage, busy, done
    );

    modport slave (
        output start, stall,
        input  tw_addr, issue, bfly_valid, addr_a, addr_b, stage, busy, done
    );

endinterface

// File: rtl/fft_bfly_addr_gen.sv
// Combinational map from (stage, butterfly index) to the in-place operand
// addresses and the twiddle index for a radix-2 DIT FFT.
module fft_bfly_addr_gen
    import fft_pkg::*;
#(
    parameter int unsigned SIZE_DATA_FI = 3
) (
    input  logic [STG_W-1:0]        i_s,
    input  logic [SIZE_DATA_FI-2:0] i_j,
    output logic [SIZE_DATA_FI-1:0] o_a,
    output logic [SIZE_DATA_FI-1:0] o_b,
    output logic [SIZE_DATA_FI-2:0] o_tw
);
    localparam int unsigned L = SIZE_DATA_FI;

    logic [L-2:0] w_mask;
    logic [L-2:0] w_pos;
    logic [L-2:0] w_grp;
    logic [L-1:0] w_half;

    // The mask saturates to all-ones in the last stage, where pos == j.
    assign w_mask = ~({(L-1){1'b1}} << i_s);
    assign w_pos  = i_j & w_mask;
    assign w_grp  = i_j >> i_s;
    assign w_half = L'(1) << i_s;

    assign o_a  = ({1'b0, w_grp} << (i_s + 3'd1)) | {1'b0, w_pos};
    assign o_b  = o_a | w_half;
    assign o_tw = w_pos << (3'(L - 1) - i_s);

endmodule

// File: rtl/fft_stage_sched.sv
// Stage/butterfly sequencer for the in-place radix-2 DIT FFT: issues one
// butterfly per cycle, inserts inter-stage gaps, honours stall, reports done.
module fft_stage_sched #(
    parameter int unsigned SIZE_DATA_FI = 3,
    parameter int unsigned STAGE_GAP    = 2
) (
    input logic              clk,
    input logic              rst,
    fft_stage_sched_if.master bus
);
    import fft_pkg::*;

    localparam int unsigned        L        = SIZE_DATA_FI;
    localparam int unsigned        J_W      = L - 1;
    localparam logic [J_W-1:0]     J_LAST   = J_W'(nfft(L) / 2 - 1);
    localparam logic [STG_W-1:0]   S_LAST   = STG_W'(L - 1);
    localparam logic [3:0]         GAP_LAST = 4'((STAGE_GAP == 0) ? 0 : STAGE_GAP - 1);

    state_t           r_state, w_state_nxt;
    logic [STG_W-1:0] r_s, w_s_nxt;
    logic [J_W-1:0]   r_j, w_j_nxt;
    logic [3:0]       r_gap, w_gap_nxt;

    logic             w_issue;
    logic             w_busy;
    logic             w_finish;
    logic [L-1:0]     w_a;
    logic [L-1:0]     w_b;
    logic [L-2:0]     w_tw;

    logic             r_bfly_valid;
    logic [L-1:0]     r_addr_a;
    logic [L-1:0]     r_addr_b;
    logic [STG_W-1:0] r_stage;
    logic             r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_j     <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_j     <= w_j_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_j_nxt     = r_j;
        w_gap_nxt   = r_gap;
        if (!bus.stall || r_state == ST_IDLE) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        w_state_nxt = ST_RUN;
                        w_s_nxt     = '0;
                        w_j_nxt     = '0;
                        w_gap_nxt   = '0;
                    end
                end
                ST_RUN: begin
                    if (r_j == J_LAST) begin
                        if (r_s == S_LAST) begin
                            w_state_nxt = ST_FLUSH;
                        end else begin
                            w_state_nxt = (STAGE_GAP == 0) ? ST_RUN : ST_GAP;
                            w_s_nxt     = r_s + 1'b1;
                            w_j_nxt     = '0;
                            w_gap_nxt   = '0;
                        end
                    end else begin
                        w_j_nxt = r_j + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_gap_nxt   = '0;
                    end else begin
                        w_gap_nxt = r_gap + 1'b1;
                    end
                end
                ST_FLUSH: w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_issue  = (r_state == ST_RUN) && !bus.stall;
        w_busy   = (r_state != ST_IDLE);
        w_finish = (r_state == ST_FLUSH) && !bus.stall;
    end

    fft_bfly_addr_gen #(
        .SIZE_DATA_FI(L)
    ) u_addr_gen (
        .i_s (r_s),
        .i_j (r_j),
        .o_a (w_a),
        .o_b (w_b),
        .o_tw(w_tw)
    );

    // Delay stage keeps running under stall so bfly_valid tracks issue by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bfly_valid <= 1'b0;
            r_addr_a     <= '0;
            r_addr_b     <= '0;
            r_stage      <= '0;
            r_done       <= 1'b0;
        end else begin
            r_bfly_valid <= w_issue;
            r_done       <= w_finish;
            if (w_issue) begin
                r_addr_a <= w_a;
                r_addr_b <= w_b;
                r_stage  <= r_s;
            end
        end
    end

    assign bus.tw_addr    = w_tw;
    assign bus.issue      = w_issue;
    assign bus.bfly_valid = r_bfly_valid;
    assign bus.addr_a     = r_addr_a;
    assign bus.addr_b     = r_addr_b;
    assign bus.stage      = r_stage;
    assign bus.busy       = w_busy;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_fft_stage_sched.sv
// Scoreboard bench for fft_stage_sched: an N=8/gap=2 instance and an N=16/gap=0
// instance, with expected issue, butterfly and done events queued per run.
module tb_fft_stage_sched;

    typedef struct {
        int c;
        int tw;
    } iss_t;

    typedef struct {
        int c;
        int a;
        int b;
        int s;
    } bf_t;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    iss_t qa_iss[$];
    bf_t  qa_bf[$];
    int   qa_done[$];
    iss_t qb_iss[$];
    bf_t  qb_bf[$];
    int   qb_done[$];

    // N = 8 reference tables, in issue order across stages 0, 1, 2
    int tw8[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int a8[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int b8[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};

    fft_stage_sched_if #(.SIZE_DATA_FI(3)) ifa ();
    fft_stage_sched_if #(.SIZE_DATA_FI(4)) ifb ();

    fft_stage_sched #(.SIZE_DATA_FI(3), .STAGE_GAP(2)) dut_a (
        .clk(clk),
        .rst(rst_a),
        .bus(ifa)
    );

    fft_stage_sched #(.SIZE_DATA_FI(4), .STAGE_GAP(0)) dut_b (
        .clk(clk),
        .rst(rst_b),
        .bus(ifb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got an event at cycle %0d, expected none", nm, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        iss_t ei;
        bf_t  eb;
        if (ifa.issue) begin
            if (qa_iss.size() == 0) unexpected("A_issue");
            else begin
                ei = qa_iss.pop_front();
                chk("A_issue_cycle", cyc, ei.c);
                chk("A_tw_addr", int'(ifa.tw_addr), ei.tw);
            end
        end
        if (ifa.bfly_valid) begin
            if (qa_bf.size() == 0) unexpected("A_bfly_valid");
            else begin
                eb = qa_bf.pop_front();
                chk("A_bfly_cycle", cyc, eb.c);
                chk("A_addr_a", int'(ifa.addr_a), eb.a);
                chk("A_addr_b", int'(ifa.addr_b), eb.b);
                chk("A_stage", int'(ifa.stage), eb.s);
            end
        end
        if (ifa.done) begin
            if (qa_done.size() == 0) unexpected("A_done");
            else begin
                chk("A_done_cycle", cyc, qa_done.pop_front());
                chk("A_busy_at_done", int'(ifa.busy), 0);
            end
        end
    end

    always @(negedge clk) begin
        iss_t ei;
        bf_t  eb;
        if (ifb.issue) begin
            if (qb_iss.size() == 0) unexpected("B_issue");
            else begin
                ei = qb_iss.pop_front();
                chk("B_issue_cycle", cyc, ei.c);
                chk("B_tw_addr", int'(ifb.tw_addr), ei.tw);
            end
        end
        if (ifb.bfly_valid) begin
            if (qb_bf.size() == 0) unexpected("B_bfly_valid");
            else begin
                eb = qb_bf.pop_front();
                chk("B_bfly_cycle", cyc, eb.c);
                chk("B_addr_a", int'(ifb.addr_a), eb.a);
                chk("B_addr_b", int'(ifb.addr_b), eb.b);
                chk("B_stage", int'(ifb.stage), eb.s);
            end
        end
        if (ifb.done) begin
            if (qb_done.size() == 0) unexpected("B_done");
            else begin
                chk("B_done_cycle", cyc, qb_done.pop_front());
                chk("B_busy_at_done", int'(ifb.busy), 0);
            end
        end
    end

    // Queue one N=8 run: stalls starting at relative cycle stall_from shift later issues.
    task automatic push_a(input int base, input int stall_from, input int stall_len,
                          input int nst, input bit want_done);
        int k;
        int c;
        for (int st = 0; st < nst; st++) begin
            for (int j = 0; j < 4; j++) begin
                k = st * 4 + j;
                c = base + 1 + st * 6 + j;
                if (stall_len > 0 && (c - base) >= stall_from) c += stall_len;
                qa_iss.push_back('{c: c, tw: tw8[k]});
                qa_bf.push_back('{c: c + 1, a: a8[k], b: b8[k], s: st});
            end
        end
        if (want_done) qa_done.push_back(base + 18 + stall_len);
    endtask

    task automatic push_b(input int base);
        int c;
        int half;
        int pos;
        int a;
        for (int st = 0; st < 4; st++) begin
            for (int j = 0; j < 8; j++) begin
                c    = base + 1 + st * 8 + j;
                half = 1 << st;
                pos  = j % half;
                a    = (j / half) * 2 * half + pos;
                qb_iss.push_back('{c: c, tw: pos * (8 >> st)});
                qb_bf.push_back('{c: c + 1, a: a, b: a + half, s: st});
            end
        end
        qb_done.push_back(base + 34);
    endtask

    task automatic start_a(output int base);
        ifa.start = 1'b1;
        base = cyc;
        step(1);
        ifa.start = 1'b0;
    endtask

    task automatic chk_idle_a(input string tag);
        @(negedge clk);
        chk({tag, "_issue"}, int'(ifa.issue), 0);
        chk({tag, "_bfly_valid"}, int'(ifa.bfly_valid), 0);
        chk({tag, "_busy"}, int'(ifa.busy), 0);
        chk({tag, "_done"}, int'(ifa.done), 0);
        chk({tag, "_tw_addr"}, int'(ifa.tw_addr), 0);
        chk({tag, "_addr_a"}, int'(ifa.addr_a), 0);
        chk({tag, "_addr_b"}, int'(ifa.addr_b), 0);
        chk({tag, "_stage"}, int'(ifa.stage), 0);
    endtask

    initial begin
        int base;
        int base2;
        ifa.start = 1'b0;
        ifa.stall = 1'b0;
        ifb.start = 1'b0;
        ifb.stall = 1'b0;
        step(3);
        chk_idle_a("A_reset");
        chk("B_reset_busy", int'(ifb.busy), 0);
        chk("B_reset_bfly_valid", int'(ifb.bfly_valid), 0);
        step(1);
        rst_a = 1'b0;
        rst_b = 1'b0;
        step(2);

        // Single run: issues 1-4, 7-10, 13-16, done in cycle 18
        start_a(base);
        push_a(base, 0, 0, 3, 1'b1);
        chk("A_busy_cycle1", int'(ifa.busy), 1);
        step(22);

        // Three stall cycles in stage 1 (cycles 8-10)
        start_a(base);
        push_a(base, 8, 3, 3, 1'b1);
        step(7);
        ifa.stall = 1'b1;
        step(3);
        ifa.stall = 1'b0;
        step(15);

        // start pulsed during the stage 0/1 gap is ignored
        start_a(base);
        push_a(base, 0, 0, 3, 1'b1);
        step(4);
        ifa.start = 1'b1;
        step(1);
        ifa.start = 1'b0;
        step(20);

        // start in the done cycle launches a second run immediately
        start_a(base);
        push_a(base, 0, 0, 3, 1'b1);
        step(17);
        ifa.start = 1'b1;
        base2 = cyc;
        push_a(base2, 0, 0, 3, 1'b1);
        step(1);
        ifa.start = 1'b0;
        step(22);

        // Reset during cycle 6 aborts the run with no done
        start_a(base);
        push_a(base, 0, 0, 1, 1'b0);
        step(5);
        rst_a = 1'b1;
        step(1);
        rst_a = 1'b0;
        chk_idle_a("A_abort");
        step(3);
        start_a(base);
        push_a(base, 0, 0, 3, 1'b1);
        step(22);

        // N = 16 with no gap: 32 back-to-back issues, done in cycle 34
        ifb.start = 1'b1;
        base = cyc;
        push_b(base);
        step(1);
        ifb.start = 1'b0;
        chk("B_busy_cycle1", int'(ifb.busy), 1);
        step(38);

        chk("A_issue_left", qa_iss.size(), 0);
        chk("A_bfly_left", qa_bf.size(), 0);
        chk("A_done_left", qa_done.size(), 0);
        chk("B_issue_left", qb_iss.size(), 0);
        chk("B_bfly_left", qb_bf.size(), 0);
        chk("B_done_left", qb_done.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_stage_sched.md
# fft_stage_sched

Sequencing controller for the in-place radix-2 DIT FFT core. After a `start` pulse it walks all log2(NFFT) stages and issues one butterfly per cycle. For each butterfly it drives the twiddle address to the cos/sin ROM (1-cycle registered read) and produces the butterfly operand addresses, delayed to line up with the ROM output. It also inserts programmable gap cycles between stages so the datapath can finish write-back, honours a stall input, and reports busy/done.

## Interface
- `SIZE_DATA_FI`, default 3: log2(NFFT); legal range 2..4, the same range the twiddle ROM supports.
- `STAGE_GAP`, default 2: idle cycles inserted between consecutive stages; legal range 0..15.
- `clk`  in  1  sole clock; all logic updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a transform; sampled only in IDLE.
- `stall`  in  1  while high, the FSM, counters and issue are frozen.
- `tw_addr`  out  SIZE_DATA_FI-1  twiddle index to the ROM `addr` input.
- `issue`  out  1  a butterfly is issued this cycle (`tw_addr` is meaningful).
- `bfly_valid`  out  1  `issue` delayed 1 cycle; aligned with ROM cos/sin.
- `addr_a`  out  SIZE_DATA_FI  upper-leg data address; aligned with `bfly_valid`.
- `addr_b`  out  SIZE_DATA_FI  lower-leg data address; aligned with `bfly_valid`.
- `stage`  out  3  current stage index; aligned with `bfly_valid`.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when the transform completes.

## Operation
- Definitions: N = 2**SIZE_DATA_FI, L = SIZE_DATA_FI.
  - Stage counter s runs 0..L-1; butterfly counter j runs 0..N/2-1.
- Address map, with half = 2**s, pos = j mod half, grp = j >> s:
  - a = grp*2*half + pos
  - b = a + half
  - tw = pos << (L-1-s)
  - Input data is bit-reversed upstream; output is natural order.
- FSM states: IDLE, RUN, GAP, FLUSH.
  - IDLE: if `start`, clear s and j and go to RUN.
  - RUN: assert `issue` and the current `tw_addr`, then increment j.
    - After j = N/2-1 with s < L-1: increment s, clear j, go to GAP (or straight to RUN if STAGE_GAP = 0).
    - After j = N/2-1 with s = L-1: go to FLUSH.
  - GAP: count STAGE_GAP cycles with `issue` low, then go to RUN.
  - FLUSH: one cycle, no issue; the last `bfly_valid` appears here. Go to IDLE and register `done` = 1.
- Stall:
  - When `stall` is high, state, s, j and the gap counter hold, and `issue` is 0.
  - `tw_addr` holds its last value.
  - The 1-cycle delay stage still advances, so `bfly_valid` drops one cycle after `issue` drops.
  - `stall` has no effect in IDLE.
- `start` outside IDLE is ignored. A `start` in the cycle `done` is high is accepted, since the state is already IDLE.
- Reset values: state IDLE; s = 0, j = 0; `tw_addr` = 0, `addr_a` = 0, `addr_b` = 0, `stage` = 0; `issue` = 0, `bfly_valid` = 0, `busy` = 0, `done` = 0.
  - Reset asserted mid-transform aborts it immediately; no `done` is produced.

## Timing
- `start` sampled high at edge 0:
  - `busy` goes high and the first `issue` with `tw_addr` valid occur in cycle 1.
  - ROM cos/sin and the matching `bfly_valid`, `addr_a`, `addr_b`, `stage` are valid in cycle 2.
- Issue-phase length without stalls: L*N/2 + (L-1)*STAGE_GAP cycles, then 1 FLUSH cycle.
  - `done` rises on the cycle after FLUSH, at the same time `busy` falls.
- Example, N = 8, STAGE_GAP = 2:
  - issues in cycles 1-4, 7-10, 13-16;
  - FLUSH in cycle 17;
  - `done` in cycle 18.
- Each stall cycle delays every later event by exactly one cycle.

## Structure
- Shared package `fft_pkg` holds:
  - the state enum (IDLE, RUN, GAP, FLUSH);
  - the stage-index width constant (3);
  - a function that computes NFFT from SIZE_DATA_FI.
- Sub-module `fft_bfly_addr_gen`: pure mapping from (s, j) to (a, b, tw), parameterised by SIZE_DATA_FI.
  - Instantiated once by the controller.
  - Its a and b outputs feed the 1-cycle delay register.

## Test plan
- N = 8, STAGE_GAP = 2, single start:
  - `tw_addr` sequence is 0,0,0,0 | 0,2,0,2 | 0,1,2,3.
  - (a,b) with `bfly_valid` is (0,1)(2,3)(4,5)(6,7) | (0,2)(1,3)(4,6)(5,7) | (0,4)(1,5)(2,6)(3,7).
  - `done` appears in cycle 18.
- N = 16, STAGE_GAP = 0:
  - 32 back-to-back issues.
  - Stage 3 `tw_addr` runs 0..7.
  - `done` appears in cycle 34.
- Stall held for 3 cycles in the middle of stage 1 (N = 8):
  - `issue` is low for exactly 3 cycles, with no address skipped or repeated.
  - `done` moves from cycle 18 to cycle 21.
- `start` pulsed while busy:
  - it is ignored, with one `done` only.
- `start` asserted in the `done` cycle:
  - a new run begins with `issue` in the next cycle.
- `rst` pulsed in cycle 6:
  - all outputs are 0 in cycle 7, there is no `done`, and `busy` is 0.
  - A subsequent `start` produces the full, correct sequence.
